// File: rtl/umi_tx_arbiter.sv
// rtl/umi_tx_arbiter.sv - round-robin, burst-locking arbiter feeding a one-entry registered TX flit stage
module umi_tx_arbiter #(
  parameter int N  = 4,
  parameter int DW = 256,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*DW-1:0] in_data,
  input  logic [N-1:0]    in_last,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [N-1:0]    req_mask,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic [CW-1:0]   cur_grant,
  output logic [31:0]     pkt_count
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_n;
  logic [CW-1:0] ptr, cand, sel;
  logic          cand_found, can_load, accept, sel_last;
  logic [DW-1:0] sel_data;
  logic [DW-1:0] flits [N];

  for (genvar i = 0; i < N; i++) begin : g_split
    assign flits[i] = in_data[i*DW +: DW];
  end

  assign can_load = !out_valid || out_ready;
  assign busy     = (state == LOCKED);
  assign sel_data = flits[sel];
  assign sel_last = in_last[sel];

  // First enabled, valid requester after the last burst winner.
  always_comb begin : p_search
    logic [CW-1:0] idx;
    idx        = '0;
    cand       = '0;
    cand_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = CW'((int'(ptr) + k) % N);
      if (!cand_found && in_valid[idx] && req_mask[idx]) begin
        cand_found = 1'b1;
        cand       = idx;
      end
    end
  end

  // in_ready never looks at in_data/in_last; only the next state does.
  always_comb begin
    state_n  = state;
    in_ready = '0;
    accept   = 1'b0;
    sel      = cand;
    if (state == IDLE) begin
      if (cand_found && can_load) begin
        in_ready[cand] = 1'b1;
        accept         = 1'b1;
      end
    end else begin
      sel                 = cur_grant;
      in_ready[cur_grant] = can_load;
      accept              = can_load && in_valid[cur_grant];
    end
    if (accept) begin
      state_n = sel_last ? IDLE : LOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= CW'(N - 1);
      cur_grant <= '0;
      pkt_count <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_valid <= 1'b1;
        cur_grant <= sel;
        if (sel_last) begin
          ptr       <= sel;
          pkt_count <= pkt_count + 32'd1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
